cpu_run_ctrl: RTL and testbench

Run/step controller for the picoMIPS core on the DE0 board. It replaces the free-running slow-clock divider: the whole design runs on the 50 MHz board clock, and this block issues a single-cycle clock-enable `cpu_en` to the cpu. The enable follows a switch-selected mode: halt, single-step on a debounced push-button, slow run, or full-speed run. It also stops the core when the core signals a halt.

---
 rtl/cpu_run_ctrl.sv | 128 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step controller for the picoMIPS core: issues a one-cycle clock-enable
// to the cpu according to a switch-selected halt/step/slow/fast mode.
module cpu_run_ctrl #(
    parameter int unsigned DIV      = 5_000_000,
    parameter int unsigned DEBOUNCE = 500_000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] en_count
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic [2:0] {
        S_HALT,
        S_STEP,
        S_SLOW,
        S_FAST,
        S_DONE
    } state_t;

    logic [1:0]       mode_m, mode_s;
    logic             btn_m, btn_s;
    logic             btn_db, btn_db_q;
    logic [DB_W-1:0]  db_cnt;
    logic             step_evt;
    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic             cpu_en_nxt;

    // Two-flop synchronizers for the asynchronous switch and button inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_m <= '0;
            mode_s <= '0;
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            mode_m <= mode;
            mode_s <= mode_m;
            btn_m  <= step_btn;
            btn_s  <= btn_m;
        end
    end

    // Accept a new button level only after it has differed for DEBOUNCE cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt   <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign step_evt = btn_db & ~btn_db_q;

    // Next state, divider and enable; a halt request on an issued enable outranks everything.
    always_comb begin
        state_nxt  = state;
        cpu_en_nxt = 1'b0;
        div_nxt    = '0;

        if (cpu_en && halt_req) begin
            state_nxt = S_DONE;
        end else if (state == S_DONE) begin
            if (mode_s == 2'b00) state_nxt = S_HALT;
        end else begin
            case (mode_s)
                2'b00:   state_nxt = S_HALT;
                2'b01:   state_nxt = S_STEP;
                2'b10:   state_nxt = S_SLOW;
                default: state_nxt = S_FAST;
            endcase
        end

        case (state_nxt)
            S_FAST: cpu_en_nxt = 1'b1;
            S_STEP: cpu_en_nxt = (state == S_STEP) && step_evt;
            S_SLOW: begin
                if (state == S_SLOW) begin
                    if (div_cnt == DIV_W'(DIV - 1)) begin
                        cpu_en_nxt = 1'b1;
                    end else begin
                        div_nxt = div_cnt + DIV_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_HALT;
            div_cnt  <= '0;
            cpu_en   <= 1'b0;
            running  <= 1'b0;
            halted   <= 1'b0;
            en_count <= '0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_nxt;
            cpu_en   <= cpu_en_nxt;
            running  <= (state_nxt == S_SLOW) || (state_nxt == S_FAST);
            halted   <= (state_nxt == S_DONE);
            en_count <= en_count + CNT_W'(cpu_en);
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the run controller.
module tb_cpu_run_ctrl;

    localparam int unsigned DIV      = 4;
    localparam int unsigned DEBOUNCE = 3;
    localparam int unsigned CNT_W    = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       mode;
    logic             step_btn;
    logic             halt_req;
    logic             cpu_en;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] en_count;

    int n_vec = 0;
    int n_err = 0;

    cpu_run_ctrl #(.DIV(DIV), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .step_btn (step_btn),
        .halt_req (halt_req),
        .cpu_en   (cpu_en),
        .running  (running),
        .halted   (halted),
        .en_count (en_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: run mode is 0..3 (same coding as the switches), 4 means finished.
    int         m_st;
    int         m_k;
    int         m_entry;
    int         m_run;
    int         m_cnt;
    bit         m_en;
    bit         m_db;
    bit         m_rose;
    logic [1:0] mode_hist[$];
    logic       btn_hist[$];

    function automatic void model_reset();
        m_st = 0; m_k = 0; m_entry = 0; m_run = 0; m_cnt = 0;
        m_en = 1'b0; m_db = 1'b0; m_rose = 1'b0;
        mode_hist.delete();
        btn_hist.delete();
    endfunction

    // One clock edge; md/b/hr are the input values present at that edge.
    function automatic void model_edge(logic [1:0] md, logic b, logic hr);
        int  ms;
        int  nst;
        bit  bs;
        bit  evt;
        bit  nen;
        m_k++;
        ms  = (mode_hist.size() >= 2) ? int'(mode_hist[mode_hist.size()-2]) : 0;
        bs  = (btn_hist.size() >= 2) ? bit'(btn_hist[btn_hist.size()-2]) : 1'b0;
        evt = m_rose;
        m_rose = 1'b0;
        if (bs != m_db) begin
            m_run++;
            if (m_run == int'(DEBOUNCE)) begin
                m_db   = bs;
                m_run  = 0;
                m_rose = bs;
            end
        end else begin
            m_run = 0;
        end
        if (m_en && hr)   nst = 4;
        else if (m_st == 4) nst = (ms == 0) ? 0 : 4;
        else              nst = ms;
        nen = (nst == 3) ||
              (nst == 1 && m_st == 1 && evt) ||
              (nst == 2 && m_st == 2 && ((m_k - m_entry) % int'(DIV)) == 0);
        if (nst == 2 && m_st != 2) m_entry = m_k;
        m_cnt = (m_cnt + int'(m_en)) % (1 << CNT_W);
        m_en  = nen;
        m_st  = nst;
        mode_hist.push_back(md);
        btn_hist.push_back(b);
        if (mode_hist.size() > 4) void'(mode_hist.pop_front());
        if (btn_hist.size() > 4)  void'(btn_hist.pop_front());
    endfunction

    function automatic logic [CNT_W+2:0] exp_vec();
        return {m_en, (m_st == 2 || m_st == 3), (m_st == 4), CNT_W'(m_cnt)};
    endfunction

    // Advance one clock edge on both DUT and model; returns at edge + 1.
    task automatic tick();
        logic [1:0] md;
        logic       b;
        logic       hr;
        md = mode; b = step_btn; hr = halt_req;
        @(posedge clk);
        model_edge(md, b, hr);
        #1;
    endtask

    // Asynchronous reset pulse straddling one edge; leaves at edge + 1 with reset low.
    task automatic apply_reset(input logic [1:0] md);
        mode = md; step_btn = 1'b0; halt_req = 1'b0;
        #2 reset = 1'b1;
        #1 model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 2'b11; step_btn = 1'b0; halt_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({cpu_en, running, halted, en_count} !== '0) begin
            n_err++;
            $display("FAIL reset_values: got %b expected 0", {cpu_en, running, halted, en_count});
        end
        reset = 1'b0;
    endtask

    task automatic test_fast();
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if ({cpu_en, running, halted, en_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL fast_model edge %0d: got %b expected %b", i+1, {cpu_en, running, halted, en_count}, exp_vec());
            end
            if (i == 1) begin
                n_vec++;
                if (cpu_en !== 1'b0) begin
                    n_err++;
                    $display("FAIL fast_latency_early: got cpu_en=%b expected 0", cpu_en);
                end
            end
            if (i == 2) begin
                n_vec++;
                if ({cpu_en, running} !== 2'b11) begin
                    n_err++;
                    $display("FAIL fast_first_enable: got en/run=%b expected 11", {cpu_en, running});
                end
            end
            if (i == 17 || i == 18) begin
                n_vec++;
                if (en_count !== CNT_W'((i == 17) ? 15 : 0)) begin
                    n_err++;
                    $display("FAIL fast_wrap edge %0d: got en_count=%0d expected %0d", i+1, en_count, (i == 17) ? 15 : 0);
                end
            end
        end
    endtask

    task automatic test_slow();
        bit exp_en;
        mode = 2'b10;
        for (int i = 1; i <= 24; i++) begin
            tick();
            exp_en = (i <= 2) || (i >= 7 && ((i - 7) % 4) == 0);
            n_vec++;
            if ({cpu_en, running} !== {exp_en, 1'b1}) begin
                n_err++;
                $display("FAIL slow_period edge %0d: got en/run=%b expected %b", i, {cpu_en, running}, {exp_en, 1'b1});
            end
            n_vec++;
            if ({cpu_en, running, halted, en_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL slow_model edge %0d: got %b expected %b", i, {cpu_en, running, halted, en_count}, exp_vec());
            end
        end
    endtask

    task automatic test_step_bounce();
        int pulses_first;
        int pulses;
        int first_at;
        pulses = 0; pulses_first = 0; first_at = -1;
        apply_reset(2'b01);
        repeat (4) tick();
        for (int i = 0; i < 30; i++) begin
            step_btn = (i == 0) || (i >= 2 && i <= 12) || (i >= 21 && i <= 28);
            tick();
            if (cpu_en === 1'b1) begin
                pulses++;
                if (i <= 20) pulses_first++;
                if (first_at < 0) first_at = i;
            end
            n_vec++;
            if ({cpu_en, running, halted, en_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL step_model tick %0d: got %b expected %b", i, {cpu_en, running, halted, en_count}, exp_vec());
            end
        end
        n_vec++;
        if (first_at != 2 + int'(DEBOUNCE) + 2 || pulses_first != 1) begin
            n_err++;
            $display("FAIL step_bounce: got first pulse at %0d count %0d expected at %0d count 1", first_at, pulses_first, 2 + DEBOUNCE + 2);
        end
        n_vec++;
        if (pulses != 2 || en_count !== CNT_W'(2)) begin
            n_err++;
            $display("FAIL step_repress: got pulses=%0d en_count=%0d expected 2/2", pulses, en_count);
        end
    endtask

    task automatic test_halt_req();
        bit fired;
        fired = 1'b0;
        apply_reset(2'b11);
        for (int i = 0; i < 30 && !fired; i++) begin
            halt_req = m_en && (m_cnt == 4);
            fired = halt_req;
            tick();
            halt_req = 1'b0;
            n_vec++;
            if ({cpu_en, running, halted, en_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL halt_model tick %0d: got %b expected %b", i, {cpu_en, running, halted, en_count}, exp_vec());
            end
        end
        n_vec++;
        if (!fired || {cpu_en, halted, en_count} !== {2'b01, CNT_W'(5)}) begin
            n_err++;
            $display("FAIL halt_enter: got en/halted=%b en_count=%0d expected 01/5", {cpu_en, halted}, en_count);
        end
        mode = 2'b10;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++;
            if ({cpu_en, running, halted} !== 3'b001) begin
                n_err++;
                $display("FAIL halt_sticky tick %0d: got en/run/halted=%b expected 001", i, {cpu_en, running, halted});
            end
        end
        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (halted !== (i < 2) || cpu_en !== 1'b0) begin
                n_err++;
                $display("FAIL halt_clear tick %0d: got halted=%b en=%b expected %b/0", i, halted, cpu_en, i < 2);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit reached;
        reached = 1'b0;
        apply_reset(2'b10);
        for (int i = 0; i < 40 && !reached; i++) begin
            tick();
            reached = (m_st == 2) && (m_k - m_entry == 2);
        end
        n_vec++;
        if (!reached || running !== 1'b1) begin
            n_err++;
            $display("FAIL midrun_setup: got reached=%b running=%b expected 1/1", reached, running);
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({cpu_en, running, halted, en_count} !== '0) begin
            n_err++;
            $display("FAIL midrun_async_clear: got %b expected 0", {cpu_en, running, halted, en_count});
        end
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            n_vec++;
            if (cpu_en !== (i == 7 || i == 11)) begin
                n_err++;
                $display("FAIL midrun_restart edge %0d: got cpu_en=%b expected %b", i, cpu_en, i == 7 || i == 11);
            end
        end
    endtask

    task automatic test_mode_vs_step();
        int pulses;
        pulses = 0;
        apply_reset(2'b01);
        repeat (4) tick();
        for (int i = 0; i < 35; i++) begin
            step_btn = 1'b1;
            mode = (i >= 3 && i < 20) ? 2'b00 : 2'b01;
            tick();
            if (cpu_en === 1'b1) pulses++;
            n_vec++;
            if ({cpu_en, running, halted, en_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL mvs_model tick %0d: got %b expected %b", i, {cpu_en, running, halted, en_count}, exp_vec());
            end
        end
        n_vec++;
        if (pulses != 0 || en_count !== '0) begin
            n_err++;
            $display("FAIL mode_vs_step: got pulses=%0d en_count=%0d expected 0/0", pulses, en_count);
        end
        step_btn = 1'b0;
    endtask

    task automatic test_random();
        int hold_m;
        int hold_b;
        hold_m = 0; hold_b = 0;
        apply_reset(2'b11);
        for (int i = 0; i < 800; i++) begin
            if (hold_m == 0) begin
                mode   = 2'($urandom_range(0, 3));
                hold_m = int'($urandom_range(5, 40));
            end
            hold_m--;
            if (hold_b == 0) begin
                step_btn = ~step_btn;
                hold_b   = int'($urandom_range(1, 8));
            end
            hold_b--;
            halt_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) apply_reset(mode);
            tick();
            n_vec++;
            if ({cpu_en, running, halted, en_count} !== exp_vec()) begin
                n_err++;
                $display("FAIL random tick %0d: got %b expected %b", i, {cpu_en, running, halted, en_count}, exp_vec());
            end
        end
        halt_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fast();
        test_slow();
        test_step_bounce();
        test_halt_req();
        test_reset_mid_run();
        test_mode_vs_step();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
